// File: rtl/mux8_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux8_rr_arbiter
//
// Round-robin arbiter and sequencer for a shared 8:1 x 32-bit multiplexer.
// One requester at a time owns the output. Its word is registered onto o
// together with a valid strobe. A hold limit forces a hand-off once the owner
// has used the bus for MAX_HOLD consecutive cycles while someone else waits.
//
// Parameters
//   MAX_HOLD  maximum consecutive granted cycles while another requester
//             waits (1..15)
//
// Ports
//   clk      in   1   clock, rising edge
//   rst      in   1   synchronous active-high reset
//   req      in   8   request line per requester (bit i -> I<i>)
//   I0..I7   in  32   requester data words
//   gnt      out  8   registered one-hot grant, 0 when idle
//   s        out  3   registered mux select (index of current owner)
//   o        out 32   registered selected data
//   o_valid  out  1   o holds a word captured on the previous edge
//   busy     out  1   |gnt
// -----------------------------------------------------------------------------
module mux8_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  req,
    input  logic [31:0] I0,
    input  logic [31:0] I1,
    input  logic [31:0] I2,
    input  logic [31:0] I3,
    input  logic [31:0] I4,
    input  logic [31:0] I5,
    input  logic [31:0] I6,
    input  logic [31:0] I7,
    output logic [7:0]  gnt,
    output logic [2:0]  s,
    output logic [31:0] o,
    output logic        o_valid,
    output logic        busy
);

    localparam int         DATA_W = 32;
    localparam logic [3:0] LP_MAX = 4'(MAX_HOLD);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // First set bit of r scanning start, start+1, ... start+7 (mod 8).
    // The request vector is doubled so a plain part-select performs the
    // rotation; the lowest set bit of the rotated vector is the offset.
    function automatic logic [2:0] rr_pick(input logic [7:0] r,
                                           input logic [2:0] start);
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [2:0]  off;
        dbl = {r, r};
        rot = dbl[start +: 8];
        off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
        return start + off;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              r_state;
    logic [2:0]          r_ptr;
    logic [3:0]          r_cnt;
    logic [7:0]          r_gnt;
    logic [2:0]          r_s;
    logic [DATA_W-1:0]   r_o;
    logic                r_valid;

    // -------------------------------------------------------------------------
    // Next-owner decision
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0]   w_din [8];
    logic                w_owner_req;
    logic [7:0]          w_others;
    logic                w_hold_max;
    logic                w_release;
    logic [2:0]          w_next_ptr;
    logic [2:0]          w_idle_win;
    logic [2:0]          w_hand_win;

    assign w_din[0] = I0;
    assign w_din[1] = I1;
    assign w_din[2] = I2;
    assign w_din[3] = I3;
    assign w_din[4] = I4;
    assign w_din[5] = I5;
    assign w_din[6] = I6;
    assign w_din[7] = I7;

    assign w_owner_req = req[r_s];
    // While owning, r_gnt is exactly onehot(r_s), so this masks the owner.
    assign w_others    = req & ~r_gnt;
    assign w_hold_max  = (r_cnt == LP_MAX);
    assign w_release   = !w_owner_req || (w_hold_max && (|w_others));
    assign w_next_ptr  = r_s + 3'd1;
    assign w_idle_win  = rr_pick(req, r_ptr);
    // Search starts after the outgoing owner; the owner itself is masked
    // so it can never re-win its own hand-off.
    assign w_hand_win  = rr_pick(w_others, w_next_ptr);

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd0;
            r_cnt   <= 4'd0;
            r_gnt   <= 8'd0;
            r_s     <= 3'd0;
            r_o     <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (|req) begin
                        r_gnt   <= onehot8(w_idle_win);
                        r_s     <= w_idle_win;
                        r_cnt   <= 4'd1;
                        r_state <= ST_OWN;
                    end
                end

                ST_OWN: begin
                    // The owner's beat is captured whenever it still
                    // requests, including on a hold-expiry hand-off edge.
                    r_valid <= w_owner_req;
                    if (w_owner_req) begin
                        r_o <= w_din[r_s];
                    end

                    if (w_release) begin
                        r_ptr <= w_next_ptr;
                        if (|w_others) begin
                            // Back-to-back hand-off, no idle cycle.
                            r_gnt <= onehot8(w_hand_win);
                            r_s   <= w_hand_win;
                            r_cnt <= 4'd1;
                        end else begin
                            // s keeps the last owner's index.
                            r_gnt   <= 8'd0;
                            r_state <= ST_IDLE;
                        end
                    end else if (r_cnt < LP_MAX) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign gnt     = r_gnt;
    assign s       = r_s;
    assign o       = r_o;
    assign o_valid = r_valid;
    assign busy    = |r_gnt;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(r_gnt));
    a_gnt_matches_s : assert property (@(posedge clk)
        (r_gnt == 8'd0) || (r_gnt == onehot8(r_s)));
    a_state_matches_gnt : assert property (@(posedge clk)
        (r_state == ST_OWN) == (r_gnt != 8'd0));
    a_cnt_bounded : assert property (@(posedge clk) r_cnt <= LP_MAX);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

    localparam int MH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req;
    logic [31:0] din [8];
    logic [7:0]  gnt;
    logic [2:0]  s;
    logic [31:0] o;
    logic        o_valid;
    logic        busy;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .I0      (din[0]),
        .I1      (din[1]),
        .I2      (din[2]),
        .I3      (din[3]),
        .I4      (din[4]),
        .I5      (din[5]),
        .I6      (din[6]),
        .I7      (din[7]),
        .gnt     (gnt),
        .s       (s),
        .o       (o),
        .o_valid (o_valid),
        .busy    (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: owner index, round-robin start, hold length.
    bit          m_busy  = 0;
    int          m_s     = 0;
    int          m_ptr   = 0;
    int          m_cnt   = 0;
    logic [31:0] m_o     = 0;
    bit          m_valid = 0;

    function automatic int m_pick(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return start;
    endfunction

    task automatic model_update();
        logic [7:0] others;
        bit         rel;
        if (rst) begin
            m_busy = 0; m_s = 0; m_ptr = 0; m_cnt = 0; m_o = 0; m_valid = 0;
        end else if (!m_busy) begin
            m_valid = 0;
            if (req != 8'd0) begin
                m_s    = m_pick(req, m_ptr);
                m_busy = 1;
                m_cnt  = 1;
            end
        end else begin
            m_valid = req[m_s];
            if (req[m_s]) m_o = din[m_s];
            others = req;
            others[m_s] = 1'b0;
            rel = !req[m_s] || (m_cnt == MH && others != 8'd0);
            if (rel) begin
                m_ptr = (m_s + 1) % 8;
                if (others != 8'd0) begin
                    m_s   = m_pick(others, m_ptr);
                    m_cnt = 1;
                end else begin
                    m_busy = 0;
                end
            end else if (m_cnt < MH) begin
                m_cnt++;
            end
        end
    endtask

    // One clock: model sees the same inputs as the DUT edge, outputs are
    // compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("gnt",     {24'd0, gnt},    m_busy ? (32'd1 << m_s) : 32'd0);
        chk("s",       {29'd0, s},      32'(m_s));
        chk("o",       o,               m_o);
        chk("o_valid", {31'd0, o_valid}, {31'd0, m_valid});
        chk("busy",    {31'd0, busy},   {31'd0, m_busy});
    endtask

    logic [31:0] rotw [8];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rotw[0] = 32'hAA550000; rotw[1] = 32'h55AA1111;
        rotw[2] = 32'hAA552222; rotw[3] = 32'h55AA3333;
        rotw[4] = 32'hAA554444; rotw[5] = 32'h55AA5555;
        rotw[6] = 32'hAA556666; rotw[7] = 32'h55AA7777;
        for (int i = 0; i < 8; i++) din[i] = rotw[i];
        rst = 1'b1;
        req = 8'hFF;

        // Reset held two cycles with all requests high
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_gnt", {24'd0, gnt}, 32'd0);
            chk("rst_ovalid", {31'd0, o_valid}, 32'd0);
        end
        rst = 1'b0;
        step();
        chk("first_gnt", {24'd0, gnt}, 32'h01);
        chk("first_s", {29'd0, s}, 32'd0);

        // Full rotation, 4 beats per owner, wrapping back to 0
        for (int j = 1; j <= 32; j++) begin
            step();
            chk("rot_gnt", {24'd0, gnt}, 32'd1 << ((j / 4) % 8));
            chk("rot_o", o, rotw[((j - 1) / 4) % 8]);
            chk("rot_ovalid", {31'd0, o_valid}, 32'd1);
        end

        // Single requester holds indefinitely
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'h08;
        step();
        chk("single_gnt0", {24'd0, gnt}, 32'h08);
        for (int j = 0; j < 10; j++) begin
            step();
            chk("single_gnt", {24'd0, gnt}, 32'h08);
            chk("single_o", o, 32'h55AA3333);
            chk("single_ovalid", {31'd0, o_valid}, 32'd1);
        end
        req = 8'h00;
        step();
        chk("single_drop_gnt", {24'd0, gnt}, 32'd0);

        // Early drop: one bubble, then owner 2
        req = 8'h05;
        step();
        chk("drop_gnt0", {24'd0, gnt}, 32'h01);
        step(); step();
        chk("drop_o0", o, 32'hAA550000);
        req = 8'h04;
        step();
        chk("drop_bubble", {31'd0, o_valid}, 32'd0);
        chk("drop_gnt2", {24'd0, gnt}, 32'h04);
        step();
        chk("drop_o2", o, 32'hAA552222);
        chk("drop_ovalid", {31'd0, o_valid}, 32'd1);
        req = 8'h00;
        step();

        // Wrap priority after owner 7
        req = 8'h80;
        step();
        chk("wrap_gnt7", {24'd0, gnt}, 32'h80);
        step();
        req = 8'h00;
        step();
        req = 8'h81;
        step();
        chk("wrap_gnt0", {24'd0, gnt}, 32'h01);

        // Reset in the middle of an ownership
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'h10;
        step();
        chk("mid_gnt4", {24'd0, gnt}, 32'h10);
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_gnt", {24'd0, gnt}, 32'd0);
        chk("mid_rst_o", o, 32'd0);
        chk("mid_rst_ovalid", {31'd0, o_valid}, 32'd0);
        rst = 1'b0;
        req = 8'h30;
        step();
        chk("mid_after_gnt", {24'd0, gnt}, 32'h10);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 8; i++) din[i] = $urandom;
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            else if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 7)] ^= 1'b1;
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer for the shared 8:1 × 32-bit multiplexer datapath. Eight requesters each present a 32-bit word and a request line. The block grants the shared output to one requester at a time and drives the mux select. It registers the selected word onto the output bus with a valid strobe. A hold limit bounds how long one requester keeps the bus while others wait.

## Interface
Parameters:
- MAX_HOLD, 4: maximum consecutive granted cycles while another requester waits; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  8  request line per requester; bit i belongs to I<i>.
- I0..I7  in  32 each  requester data words.
- gnt  out  8  one-hot grant (registered); 0 when idle.
- s  out  3  mux select, the index of the current owner (registered).
- o  out  32  registered selected data.
- o_valid  out  1  o holds a word captured in the previous cycle.
- busy  out  1  equals |gnt.

## Operation
- Internal state: `state` ∈ {IDLE, OWN}, `ptr[2:0]` (round-robin start), `cnt[3:0]` (hold counter).
- Winner search: the first i with req[i]=1, scanning ptr, ptr+1, …, ptr+7 mod 8.
- IDLE, with req≠0: gnt←onehot(winner), s←winner, cnt←1, state←OWN.
- IDLE, with req=0: no change.
- OWN, capture: on every edge where req[s]=1, o←I[s] and o_valid←1. On all other edges o holds its value and o_valid←0.
- OWN, release condition: either
  - req[s]=0, or
  - cnt==MAX_HOLD and (req & ~gnt)≠0.
- On release:
  - ptr←s+1 mod 8.
  - If (req & ~gnt)≠0: grant the winner of the search from s+1 with bit s masked. Set cnt←1 and stay in OWN. There is no idle cycle between owners.
  - Otherwise: gnt←0 and state←IDLE. s keeps its last value.
- OWN, no release: cnt←cnt+1, saturating at MAX_HOLD. A sole requester holds the bus indefinitely.
- A hold-expiry release still captures the owner's final beat on that edge.
- Reset values: gnt=0, s=0, o=0, o_valid=0, busy=0, ptr=0, cnt=0, state=IDLE.
- rst has priority over all other inputs, including mid-ownership. No beat is captured on a reset edge.

## Timing
- Request to grant: req sampled at edge k gives gnt/s valid after edge k.
- Grant to data: first o/o_valid after edge k+1. Total request-to-data latency is 2 cycles from idle.
- Steady state: one word per cycle for the owner.
- Hand-off on hold expiry: zero bubble cycles.
- Hand-off on owner drop: one cycle with o_valid=0. The drop is seen at the edge, and the new owner's data follows on the next edge.
- Grant is never shown to a requester whose req was low at the granting edge.
- Wrap-around: ptr after owner 7 is 0.
- Simultaneous events:
  - The new requester set is sampled on the same edge as a release.
  - A request that drops on the same edge it would have been granted is not granted.

## Test plan
- Reset: hold rst for 2 cycles with req=8'hFF. Required: gnt=0, s=0, o=0, o_valid=0 throughout. After rst deasserts, gnt=8'h01 and s=0 after the first edge.
- Single requester: I3=32'h55AA3333, req=8'h08 held for 10 cycles. Required: gnt=8'h08 for the whole hold. o=55AA3333 with o_valid=1 for 10 cycles, starting one cycle after the grant. gnt=0 one edge after req drops.
- Full rotation: I0..I7 = AA550000, 55AA1111, AA552222, 55AA3333, AA554444, 55AA5555, AA556666, 55AA7777; req=8'hFF; MAX_HOLD=4. Required:
  - gnt steps 01, 02, 04, …, 80, 01, each held 4 cycles.
  - o shows each word 4 times, with o_valid continuously high after the first beat.
- Early drop: req=8'h05, and req[0] drops after 2 captured beats. Required: o_valid low for exactly one cycle, then gnt=8'h04 and o=AA552222.
- Wrap priority: after owner 7 releases, present req=8'h81. Required: the grant goes to 0, not 7.
- Reset mid-operation: assert rst while gnt=8'h10. Required: next edge gives gnt=0, o=0, o_valid=0. With req=8'h30 after reset, the grant goes to 4 (ptr reset to 0).
